// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_timer
// Description : Settable BCD countdown timer (ss / mm / hh fields) with
//               pause, alarm blink and optional auto-reload of the preset.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int NUM_FIELDS  = 2,
    parameter int TICK_DIV    = 50000000,
    parameter int FLASH_DIV   = 25000000,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_pulse,
    input  logic                    start_stop_pulse,
    input  logic [7:0]              sw,
    output logic [8*NUM_FIELDS-1:0] time_bcd,
    output logic [NUM_FIELDS-1:0]   set_field,
    output logic                    running,
    output logic                    done_pulse,
    output logic                    flash
);

    localparam int c_TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int c_FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_FLASH_W-1:0] c_FLASH_LAST = c_FLASH_W'(FLASH_DIV - 1);
    localparam logic [1:0]           c_LAST_IDX   = 2'(NUM_FIELDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_ALARM = 3'd5;

    // Hours may reach 99; so may the only field of a seconds-only timer.
    function automatic logic [3:0] f_tens_max(input int k);
        return ((k == 2) || (NUM_FIELDS == 1)) ? 4'd9 : 4'd5;
    endfunction

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic [1:0]                r_idx;
    logic [8*NUM_FIELDS-1:0]   r_time;
    logic [8*NUM_FIELDS-1:0]   r_preset;
    logic [c_TICK_W-1:0]       r_tick_cnt;
    logic [c_FLASH_W-1:0]      r_flash_cnt;
    logic                      r_flash;
    logic                      r_done;

    logic [8*NUM_FIELDS-1:0]   w_dec_time;
    logic                      w_dec_zero;
    logic                      w_time_nz;
    logic                      w_tick;
    logic                      w_sw_ok;
    logic                      w_latch;
    logic                      w_last;
    logic                      w_reload;

    assign w_sw_ok    = (sw[3:0] <= 4'd9) && (sw[7:4] <= f_tens_max(int'(r_idx)));
    assign w_latch    = (r_state == S_SET) && set_pulse && w_sw_ok;
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_time_nz  = |r_time;
    assign w_tick     = (r_state == S_RUN) && (r_tick_cnt == c_TICK_LAST);
    assign w_dec_zero = (w_dec_time == '0);
    assign w_reload   = (r_state == S_ALARM) && start_stop_pulse &&
                        (AUTO_RELOAD != 0) && (|r_preset);

    // One-second BCD decrement with a borrow rippling from seconds upward.
    always_comb begin
        logic       w_borrow;
        logic [3:0] w_u;
        logic [3:0] w_t;
        w_dec_time = r_time;
        w_borrow   = 1'b1;
        w_u        = 4'd0;
        w_t        = 4'd0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            w_u = r_time[8*k +: 4];
            w_t = r_time[8*k+4 +: 4];
            if (w_borrow) begin
                if (w_u != 4'd0) begin
                    w_dec_time[8*k +: 4] = w_u - 4'd1;
                    w_borrow             = 1'b0;
                end else if (w_t != 4'd0) begin
                    w_dec_time[8*k +: 8] = {w_t - 4'd1, 4'd9};
                    w_borrow             = 1'b0;
                end else begin
                    w_dec_time[8*k +: 8] = {f_tens_max(k), 4'd9};
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the pulse priority differs between set-side and run-side states.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (set_pulse) w_next_state = S_SET;
            end
            S_SET: begin
                if (w_latch && w_last) w_next_state = S_READY;
            end
            S_READY: begin
                if (set_pulse)                         w_next_state = S_SET;
                else if (start_stop_pulse && w_time_nz) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (start_stop_pulse)        w_next_state = S_PAUSE;
                else if (w_tick && w_dec_zero) w_next_state = S_ALARM;
            end
            S_PAUSE: begin
                if (start_stop_pulse) begin
                    if (w_time_nz) w_next_state = S_RUN;
                end else if (set_pulse) begin
                    w_next_state = S_SET;
                end
            end
            S_ALARM: begin
                if (start_stop_pulse) w_next_state = w_reload ? S_RUN : S_IDLE;
                else if (set_pulse)   w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: field index, time/preset fields, tick and flash dividers, done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx       <= 2'd0;
            r_time      <= '0;
            r_preset    <= '0;
            r_tick_cnt  <= '0;
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Index only matters in SET; parking it at zero makes every entry start at seconds.
            if (r_state != S_SET) begin
                r_idx <= 2'd0;
            end else if (w_latch) begin
                r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
            end

            if (w_latch) begin
                for (int k = 0; k < NUM_FIELDS; k++) begin
                    if (int'(r_idx) == k) begin
                        r_time[8*k +: 8]   <= sw;
                        r_preset[8*k +: 8] <= sw;
                    end
                end
            end else if (w_tick && !start_stop_pulse) begin
                r_time <= w_dec_time;
            end else if (w_reload) begin
                r_time <= r_preset;
            end

            // Divider keeps running on the pausing cycle so a coincident tick is lost,
            // holds through PAUSE, and restarts from zero on a fresh start.
            if (r_state == S_RUN) begin
                r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
            end else if ((w_next_state == S_RUN) && (r_state != S_PAUSE)) begin
                r_tick_cnt <= '0;
            end

            if (r_state != S_ALARM) begin
                r_flash_cnt <= '0;
                r_flash     <= 1'b0;
            end else if (r_flash_cnt == c_FLASH_LAST) begin
                r_flash_cnt <= '0;
                r_flash     <= ~r_flash;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end

            r_done <= (r_state == S_RUN) && (w_next_state == S_ALARM);
        end
    end

    // Outputs: the field being edited shows the switches live.
    always_comb begin
        time_bcd   = r_time;
        set_field  = '0;
        if (r_state == S_SET) begin
            for (int k = 0; k < NUM_FIELDS; k++) begin
                if (int'(r_idx) == k) begin
                    time_bcd[8*k +: 8] = sw;
                    set_field[k]       = 1'b1;
                end
            end
        end
        running    = (r_state == S_RUN);
        done_pulse = r_done;
        flash      = r_flash && (r_state == S_ALARM);
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Directed vector bench for bcd_countdown_timer (2 fields,
//               tick every 4 clocks, flash every 2) plus an auto-reload copy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_p, ss_p;
    logic [7:0]  sw;
    logic [15:0] t_bcd;
    logic [1:0]  sf;
    logic        run, done, fl;

    logic        set_a, ss_a;
    logic [7:0]  sw_a;
    logic [15:0] t_bcd_a;
    logic [1:0]  sf_a;
    logic        run_a, done_a, fl_a;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_FIELDS(2), .TICK_DIV(4), .FLASH_DIV(2), .AUTO_RELOAD(0)) u_dut (
        .clk(clk), .reset(reset), .set_pulse(set_p), .start_stop_pulse(ss_p), .sw(sw),
        .time_bcd(t_bcd), .set_field(sf), .running(run), .done_pulse(done), .flash(fl)
    );

    bcd_countdown_timer #(.NUM_FIELDS(2), .TICK_DIV(4), .FLASH_DIV(2), .AUTO_RELOAD(1)) u_dut_ar (
        .clk(clk), .reset(reset), .set_pulse(set_a), .start_stop_pulse(ss_a), .sw(sw_a),
        .time_bcd(t_bcd_a), .set_field(sf_a), .running(run_a), .done_pulse(done_a), .flash(fl_a)
    );

    typedef struct {
        logic        s;
        logic        p;
        logic [7:0]  v;
        logic [15:0] t;
        logic [1:0]  sf;
        logic        r;
        logic        d;
        logic        f;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [15:0] t, input logic [1:0] f_sf,
                           input logic r, input logic d, input logic f);
        chk({n, ".time"},  t_bcd,      t);
        chk({n, ".sf"},    16'(sf),    16'(f_sf));
        chk({n, ".run"},   16'(run),   16'(r));
        chk({n, ".done"},  16'(done),  16'(d));
        chk({n, ".flash"}, 16'(fl),    16'(f));
    endtask

    task automatic chk_ar(input string n, input logic [15:0] t, input logic [1:0] f_sf,
                          input logic r, input logic d, input logic f);
        chk({n, ".time"},  t_bcd_a,     t);
        chk({n, ".sf"},    16'(sf_a),   16'(f_sf));
        chk({n, ".run"},   16'(run_a),  16'(r));
        chk({n, ".done"},  16'(done_a), 16'(d));
        chk({n, ".flash"}, 16'(fl_a),   16'(f));
    endtask

    // One clock of stimulus on the main instance; returns just after the falling edge.
    task automatic cyc(input logic s, input logic p, input logic [7:0] v);
        @(negedge clk);
        set_p = s; ss_p = p; sw = v;
        set_a = 1'b0; ss_a = 1'b0;
        #1;
    endtask

    task automatic cyc_a(input logic s, input logic p, input logic [7:0] v);
        @(negedge clk);
        set_a = s; ss_a = p; sw_a = v;
        set_p = 1'b0; ss_p = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] seq [5];

        reset = 1'b0;
        set_p = 1'b0; ss_p = 1'b0; sw = 8'h00;
        set_a = 1'b0; ss_a = 1'b0; sw_a = 8'h00;

        //            s     p     sw     time      sf     run   done  flash
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h6A, 16'h006A, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h6A, 16'h006A, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h59, 16'h0059, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h0A, 16'h0A59, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h9A, 16'h9A59, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h60, 16'h6059, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h01, 16'h0159, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 16'h0159, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h00, 16'h0159, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h05, 16'h0105, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h01, 16'h0105, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 16'h0105, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 16'h0105, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 16'h0105, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 16'h0105, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 16'h0105, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 16'h0104, 2'b00, 1'b1, 1'b0, 1'b0};

        seq[0] = 16'h0103; seq[1] = 16'h0102; seq[2] = 16'h0101;
        seq[3] = 16'h0100; seq[4] = 16'h0059;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_ar("reset_ar", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Set entry, illegal values, start and first decrement
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].v);
            chk_all($sformatf("vec%0d", i), tbl[i].t, tbl[i].sf, tbl[i].r, tbl[i].d, tbl[i].f);
        end

        // One decrement every 4 clocks, including the 01:00 -> 00:59 borrow
        prev = 16'h0104;
        for (int j = 0; j < 5; j++) begin
            repeat (3) begin
                cyc(1'b0, 1'b0, 8'h00);
                chk($sformatf("hold%0d", j), t_bcd, prev);
            end
            cyc(1'b0, 1'b0, 8'h00);
            chk($sformatf("dec%0d", j), t_bcd, seq[j]);
            prev = seq[j];
        end

        // Pause with the divider at 2, wait, resume: decrement two clocks later
        cyc(1'b0, 1'b1, 8'h00);
        chk("pause_req.run", 16'(run), 16'h1);
        for (int j = 0; j < 20; j++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk_all($sformatf("paused%0d", j), 16'h0059, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("resume.run", 16'(run), 16'h0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("resume1", 16'h0059, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("resume2", 16'h0059, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("resume3", 16'h0058, 2'b00, 1'b1, 1'b0, 1'b0);

        // Pause on the tick cycle: that tick is lost
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        chk_all("tick_drop", 16'h0058, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk_all($sformatf("after_drop%0d", j), 16'h0058, 2'b00, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00);
        chk("after_drop.dec", t_bcd, 16'h0057);

        // Reload 00:01 from PAUSE and run to zero
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("pause_to_set.run", 16'(run), 16'h0);
        cyc(1'b1, 1'b0, 8'h01);
        chk_all("set01_f0", 16'h0001, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00);
        chk_all("set01_f1", 16'h0001, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        chk_all("ready01", 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk_all($sformatf("last_sec%0d", j), 16'h0001, 2'b00, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("alarm0", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("alarm1", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("alarm2", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("alarm3", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("alarm4", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        chk_all("alarm_ack", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        chk_all("idle_ss", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("idle_ss_ignored", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("idle_set.sf", 16'(sf), 16'h0);

        // Load 00:30, run, then reset asynchronously between clock edges
        cyc(1'b1, 1'b0, 8'h30);
        chk_all("set30_f0", 16'h0030, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("run30", 16'h0030, 2'b00, 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk_all("async_reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        chk_all("post_reset_ss", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk_all("post_reset_idle", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("post_reset_set.sf", 16'(sf), 16'h0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("post_reset_in_set.sf", 16'(sf), 16'h1);

        // Auto-reload instance: preset 00:03, run to zero, acknowledge restarts
        cyc_a(1'b1, 1'b0, 8'h00);
        cyc_a(1'b1, 1'b0, 8'h03);
        chk_ar("ar_f0", 16'h0003, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc_a(1'b1, 1'b0, 8'h00);
        chk_ar("ar_f1", 16'h0003, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc_a(1'b0, 1'b1, 8'h00);
        chk_ar("ar_ready", 16'h0003, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cyc_a(1'b0, 1'b0, 8'h00);
            chk_ar($sformatf("ar_run%0d", i), 16'(3 - (i - 1) / 4), 2'b00, 1'b1, 1'b0, 1'b0);
        end
        cyc_a(1'b0, 1'b0, 8'h00);
        chk_ar("ar_alarm0", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc_a(1'b0, 1'b1, 8'h00);
        chk_ar("ar_ack", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc_a(1'b0, 1'b0, 8'h00);
        chk_ar("ar_reloaded", 16'h0003, 2'b00, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
